serializer_scheduler: RTL and testbench

SERIALIZER_SCHEDULER -- requirements
Module: serializer_scheduler

---
 rtl/serializer_sched_pkg.sv | 8 +
 rtl/serializer_rr_arbiter.sv | 28 ++
 rtl/serializer_scheduler.sv | 90 +++++++++
 tb/tb_serializer_scheduler.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/serializer_sched_pkg.sv
// serializer_sched_pkg: FSM state type and default sizing shared by the serializer scheduler.
package serializer_sched_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DONE} state_t;
    localparam int DEF_NUM_REQ        = 4;
    localparam int DEF_DATA_BUS_WIDTH = 16;
    localparam int DEF_DATA_MOD_WIDTH = 4;
    localparam int DEF_ACK_TIMEOUT    = 4;
endpackage

// File: rtl/serializer_rr_arbiter.sv
// serializer_rr_arbiter: combinational round-robin pick, searching upward from ptr with wrap.
module serializer_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IW-1:0]      idx
);
    logic found;
    int   c;
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        c     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            c = int'(ptr) + k;
            if (c >= NUM_REQ) c = c - NUM_REQ;
            if (!found && req[c]) begin
                found  = 1'b1;
                gnt[c] = 1'b1;
                idx    = IW'(c);
            end
        end
    end
endmodule

// File: rtl/serializer_scheduler.sv
// serializer_scheduler: round-robin grants parallel words from several requesters to one serializer,
// issues each as a one-cycle strobe and tracks the serializer busy handshake with an ack timeout.
module serializer_scheduler
    import serializer_sched_pkg::*;
#(
    parameter int NUM_REQ        = DEF_NUM_REQ,
    parameter int DATA_BUS_WIDTH = DEF_DATA_BUS_WIDTH,
    parameter int DATA_MOD_WIDTH = DEF_DATA_MOD_WIDTH,
    parameter int ACK_TIMEOUT    = DEF_ACK_TIMEOUT
) (
    input  logic                                    clk_i,
    input  logic                                    srst_i,
    input  logic [NUM_REQ-1:0][DATA_BUS_WIDTH-1:0]  req_data_i,
    input  logic [NUM_REQ-1:0][DATA_MOD_WIDTH-1:0]  req_mod_i,
    input  logic [NUM_REQ-1:0]                      req_val_i,
    output logic [NUM_REQ-1:0]                      req_ready_o,
    output logic [DATA_BUS_WIDTH-1:0]               ser_data_o,
    output logic [DATA_MOD_WIDTH-1:0]               ser_mod_o,
    output logic                                    ser_val_o,
    input  logic                                    ser_busy_i,
    output logic [$clog2(NUM_REQ)-1:0]              grant_id_o,
    output logic [7:0]                              timeout_cnt_o
);
    localparam int IW = $clog2(NUM_REQ);
    state_t               state;
    logic [IW-1:0]        ptr;
    logic [IW-1:0]        sel_idx;
    logic [IW-1:0]        arb_idx;
    logic [NUM_REQ-1:0]   arb_gnt;
    logic [7:0]           tmr;
    logic                 xfer;
    serializer_rr_arbiter #(.NUM_REQ(NUM_REQ), .IW(IW)) u_arb (
        .req (req_val_i),
        .ptr (ptr),
        .gnt (arb_gnt),
        .idx (arb_idx)
    );
    assign xfer = |(req_ready_o & req_val_i) && !ser_busy_i;
    // ready is offered for a single cycle; if not taken, arbitration restarts from scratch
    always_ff @(posedge clk_i or posedge srst_i) begin
        if (srst_i) begin
            state         <= IDLE;
            ptr           <= '0;
            sel_idx       <= '0;
            tmr           <= '0;
            req_ready_o   <= '0;
            ser_data_o    <= '0;
            ser_mod_o     <= '0;
            ser_val_o     <= 1'b0;
            grant_id_o    <= '0;
            timeout_cnt_o <= '0;
        end else begin
            ser_val_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (xfer) begin
                        req_ready_o <= '0;
                        grant_id_o  <= sel_idx;
                        ser_data_o  <= req_data_i[sel_idx];
                        ser_mod_o   <= req_mod_i[sel_idx];
                        ser_val_o   <= 1'b1;
                        ptr         <= (sel_idx == IW'(NUM_REQ - 1)) ? '0 : sel_idx + 1'b1;
                        state       <= ISSUE;
                    end else if (|req_ready_o) begin
                        req_ready_o <= '0;
                    end else if (!ser_busy_i && |req_val_i) begin
                        req_ready_o <= arb_gnt;
                        sel_idx     <= arb_idx;
                    end
                end
                ISSUE: begin
                    tmr   <= '0;
                    state <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (ser_busy_i) begin
                        state <= WAIT_DONE;
                    end else if (tmr == 8'(ACK_TIMEOUT - 1)) begin
                        state         <= IDLE;
                        timeout_cnt_o <= (timeout_cnt_o == 8'hFF) ? 8'hFF : timeout_cnt_o + 8'd1;
                    end else begin
                        tmr <= tmr + 8'd1;
                    end
                end
                WAIT_DONE: state <= ser_busy_i ? WAIT_DONE : IDLE;
                default:   state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serializer_scheduler.sv
// tb_serializer_scheduler: directed checks of grant order, issue timing, ack timeout and reset behaviour.
module tb_serializer_scheduler;
    logic              clk = 1'b0;
    logic              srst;
    logic [3:0][15:0]  req_data;
    logic [3:0][3:0]   req_mod;
    logic [3:0]        req_val;
    logic [3:0]        req_ready;
    logic [15:0]       ser_data;
    logic [3:0]        ser_mod;
    logic              ser_val;
    logic              ser_busy;
    logic [1:0]        grant_id;
    logic [7:0]        timeout_cnt;
    int                total = 0;
    int                bad = 0;

    always #5 clk = ~clk;

    serializer_scheduler dut (
        .clk_i         (clk),
        .srst_i        (srst),
        .req_data_i    (req_data),
        .req_mod_i     (req_mod),
        .req_val_i     (req_val),
        .req_ready_o   (req_ready),
        .ser_data_o    (ser_data),
        .ser_mod_o     (ser_mod),
        .ser_val_o     (ser_val),
        .ser_busy_i    (ser_busy),
        .grant_id_o    (grant_id),
        .timeout_cnt_o (timeout_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ready"}, 32'(req_ready), 0);
        chk({tag, "_val"}, 32'(ser_val), 0);
        chk({tag, "_data"}, 32'(ser_data), 0);
        chk({tag, "_mod"}, 32'(ser_mod), 0);
        chk({tag, "_gid"}, 32'(grant_id), 0);
        chk({tag, "_tocnt"}, 32'(timeout_cnt), 0);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (req_ready == 4'b0 && n < 10) begin
            step();
            n++;
        end
        chk("ready_seen", 32'(req_ready != 4'b0), 1);
    endtask

    task automatic wait_val();
        int n = 0;
        while (!ser_val && n < 12) begin
            step();
            n++;
        end
        chk("val_seen", 32'(ser_val), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        srst     = 1'b1;
        req_val  = '0;
        ser_busy = 1'b0;
        req_data = {16'h4444, 16'hA5A5, 16'h2222, 16'h1111};
        req_mod  = {4'd9, 4'd0, 4'd5, 4'd3};
        #12;
        chk_zero("reset");
        srst = 1'b0;
        step();
        // single request from requester 2, serializer never answers
        req_val = 4'b0100;
        step();
        chk("single_ready", 32'(req_ready), 32'h4);
        step();
        chk("single_val", 32'(ser_val), 1);
        chk("single_data", 32'(ser_data), 32'hA5A5);
        chk("single_mod", 32'(ser_mod), 0);
        chk("single_gid", 32'(grant_id), 2);
        chk("single_ready_low", 32'(req_ready), 0);
        req_val = '0;
        repeat (4) step();
        chk("to_before", 32'(timeout_cnt), 0);
        chk("val_one_cycle", 32'(ser_val), 0);
        step();
        chk("to_after", 32'(timeout_cnt), 1);
        // round robin with all four requesting and a busy-responding serializer
        srst = 1'b1;
        #1;
        srst = 1'b0;
        req_val = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_ready();
            chk("rr_onehot", 32'($onehot(req_ready)), 1);
            chk("rr_grant", 32'(req_ready), 32'(1 << (k % 4)));
            step();
            chk("rr_val", 32'(ser_val), 1);
            chk("rr_gid", 32'(grant_id), 32'(k % 4));
            chk("rr_data", 32'(ser_data), 32'(req_data[k % 4]));
            step();
            step();
            ser_busy = 1'b1;
            repeat (16) begin
                step();
                chk("rr_no_ready", 32'(req_ready), 0);
            end
            ser_busy = 1'b0;
        end
        req_val = '0;
        repeat (3) step();
        chk("rr_no_timeout", 32'(timeout_cnt), 0);
        chk("rr_grant_hold", 32'(grant_id), 0);
        // external busy blocks all grants
        ser_busy = 1'b1;
        req_val  = 4'b1111;
        repeat (6) begin
            step();
            chk("busy_hold", 32'(req_ready), 0);
        end
        ser_busy = 1'b0;
        step();
        chk("busy_release_ready", 32'(req_ready), 32'h2);
        step();
        chk("busy_release_val", 32'(ser_val), 1);
        chk("busy_release_gid", 32'(grant_id), 1);
        req_val = '0;
        step();
        step();
        ser_busy = 1'b1;
        step();
        step();
        // asynchronous reset while the serializer is busy
        #3;
        srst = 1'b1;
        #1;
        chk_zero("async_rst");
        #2;
        srst     = 1'b0;
        ser_busy = 1'b0;
        repeat (4) begin
            step();
            chk("post_rst_no_val", 32'(ser_val), 0);
        end
        req_val = 4'b0001;
        chk("post_rst_ready_wait", 32'(req_ready), 0);
        step();
        chk("post_rst_ready", 32'(req_ready), 1);
        // repeated timeouts saturate the counter
        for (int i = 1; i <= 300; i++) begin
            wait_val();
            repeat (4) step();
            if (i == 1) chk("sat_boundary", 32'(timeout_cnt), 0);
            step();
            chk("sat_cnt", 32'(timeout_cnt), 32'(i > 255 ? 255 : i));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
